// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one decryption round per clock, round keys
// fetched by index from an external key-schedule store.
module aes_inv_cipher_iter #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] ct_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic [127:0] pt_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int unsigned DW = 128;
  localparam int unsigned KW = 4;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   st_reg, st_nxt, pt_nxt, sub_c;
  logic [KW-1:0]   rnd, rnd_nxt;
  logic            out_valid_nxt;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i of the state sits at [127-8i -: 8]; byte index = row + 4*column.
  function automatic logic [DW-1:0] inv_shift_rows(input logic [DW-1:0] s);
    logic [DW-1:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
    return o;
  endfunction

  function automatic logic [DW-1:0] inv_sub_bytes(input logic [DW-1:0] s);
    logic [DW-1:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    return o;
  endfunction

  // Per byte: x2/x4/x8 by chained xtime, then the {09,0b,0d,0e} multiples.
  function automatic logic [DW-1:0] inv_mix_columns(input logic [DW-1:0] s);
    logic [DW-1:0] o;
    logic [31:0]   col, m9, mb, md, me;
    logic [7:0]    a, x2, x4, x8;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      col = s[127-32*c -: 32];
      m9 = '0; mb = '0; md = '0; me = '0;
      for (int i = 0; i < 4; i++) begin
        a  = col[31-8*i -: 8];
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        m9[31-8*i -: 8] = x8 ^ a;
        mb[31-8*i -: 8] = x8 ^ x2 ^ a;
        md[31-8*i -: 8] = x8 ^ x4 ^ a;
        me[31-8*i -: 8] = x8 ^ x4 ^ x2;
      end
      for (int j = 0; j < 4; j++)
        o[127-32*c-8*j -: 8] = me[31-8*j -: 8] ^ mb[31-8*((j+1)%4) -: 8]
                             ^ md[31-8*((j+2)%4) -: 8] ^ m9[31-8*((j+3)%4) -: 8];
    end
    return o;
  endfunction

  assign sub_c = inv_sub_bytes(inv_shift_rows(st_reg));

  // Next-state, datapath updates and key-index request
  always_comb begin
    state_nxt     = state;
    st_nxt        = st_reg;
    rnd_nxt       = rnd;
    pt_nxt        = pt_out;
    out_valid_nxt = out_valid;
    in_ready      = 1'b0;
    busy          = 1'b0;
    rk_idx        = '0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        rk_idx   = KW'(NR);
        if (in_valid) begin
          st_nxt    = ct_in ^ rk_data;
          rnd_nxt   = KW'(NR - 1);
          state_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        busy   = 1'b1;
        rk_idx = rnd;
        st_nxt = inv_mix_columns(sub_c ^ rk_data);
        if (rnd == KW'(1)) state_nxt = S_FINAL;
        else               rnd_nxt   = rnd - KW'(1);
      end
      S_FINAL: begin
        busy          = 1'b1;
        pt_nxt        = sub_c ^ rk_data;
        out_valid_nxt = 1'b1;
        state_nxt     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      st_reg    <= '0;
      rnd       <= '0;
      pt_out    <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      st_reg    <= st_nxt;
      rnd       <= rnd_nxt;
      pt_out    <= pt_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule
